// File: rtl/arrive_depart_monitor_if.sv
// arrive_depart_monitor_if
//   Groups the switch inputs, error clear and occupancy outputs of
//   arrive_depart_monitor into one bundle. clk and rst stay plain ports.
//   There is no valid/ready handshake on this bundle: the switches are raw
//   asynchronous levels, the pulses are single-cycle events that the
//   consumer must sample every cycle, and count/full/empty/overflow/
//   underflow are plain levels.
//
//   Ports (slave = monitor side):
//     arriveSwitch [LANES]  in   raw arrive switch per lane
//     departSwitch [LANES]  in   raw depart switch per lane
//     clr_err               in   synchronous clear of overflow/underflow
//     arrive_pulse [LANES]  out  one-cycle pulse per accepted arrive rise
//     depart_pulse [LANES]  out  one-cycle pulse per accepted depart rise
//     count        [CW]     out  occupancy 0..CAPACITY
//     full, empty           out  count decodes
//     overflow, underflow   out  sticky saturation flags
interface arrive_depart_monitor_if #(
  parameter int LANES    = 2,
  parameter int CAPACITY = 15
);
  localparam int CW = $clog2(CAPACITY + 1);

  logic [LANES-1:0] arriveSwitch;
  logic [LANES-1:0] departSwitch;
  logic             clr_err;
  logic [LANES-1:0] arrive_pulse;
  logic [LANES-1:0] depart_pulse;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport slave (
    input  arriveSwitch, departSwitch, clr_err,
    output arrive_pulse, depart_pulse, count, full, empty, overflow, underflow
  );

  modport master (
    output arriveSwitch, departSwitch, clr_err,
    input  arrive_pulse, depart_pulse, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/arrive_depart_monitor.sv
// arrive_depart_monitor
//   Per-lane arrive/depart switch conditioning (2-flop synchroniser,
//   debounce, rising-edge pulse) feeding one saturating occupancy counter
//   with full/empty decodes and sticky overflow/underflow flags.
//
//   Ports:
//     clk  in  system clock, all state on rising edge
//     rst  in  asynchronous active-high reset
//     io   arrive_depart_monitor_if.slave (switches, clr_err, pulses,
//          count, full, empty, overflow, underflow)
module arrive_depart_monitor #(
  parameter int LANES    = 2,
  parameter int DEBOUNCE = 4,
  parameter int CAPACITY = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  arrive_depart_monitor_if.slave   io
);
  localparam int CW = $clog2(CAPACITY + 1);
  localparam int NB = 2 * LANES;                 // conditioned bits
  localparam int DW = $clog2(DEBOUNCE + 1);      // debounce counter width
  localparam int PW = $clog2(LANES + 1);         // popcount width
  localparam int NW = ((CW > PW) ? CW : PW) + 2; // signed arithmetic width

  // ---------------- switch conditioning ----------------
  // Bits [LANES-1:0] are arrive lanes, bits [NB-1:LANES] are depart lanes.
  logic [NB-1:0] raw;
  logic [NB-1:0] sync1_q, sync2_q;
  logic [NB-1:0] level_q, level_d;
  logic [NB-1:0] level_dly_q;
  logic [NB-1:0] pulse;
  logic [DW-1:0] deb_cnt_q [NB];
  logic [DW-1:0] deb_cnt_d [NB];

  always_comb raw = {io.departSwitch, io.arriveSwitch};

  // The counter holds the number of consecutive disagreeing samples seen so
  // far; the DEBOUNCE-th disagreeing sample flips level and the counter
  // returns to 0. Any agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NB; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DW'(DEBOUNCE - 1)) begin
          level_d[i] = ~level_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      for (int i = 0; i < NB; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      for (int i = 0; i < NB; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  // Rising edges of the debounced level only.
  always_comb pulse = level_q & ~level_dly_q;

  assign io.arrive_pulse = pulse[LANES-1:0];
  assign io.depart_pulse = pulse[NB-1:LANES];

  // ---------------- occupancy counter ----------------
  logic [CW-1:0]        count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic [PW-1:0]        n_arr, n_dep;
  logic signed [NW-1:0] next_val;
  logic                 ovf_evt, udf_evt;

  // Arrivals and departures of the same cycle net out before saturation,
  // so a full counter seeing +1/-1 stays put without raising a flag.
  always_comb begin
    n_arr = '0;
    n_dep = '0;
    for (int i = 0; i < LANES; i++) begin
      n_arr = n_arr + PW'(pulse[i]);
      n_dep = n_dep + PW'(pulse[LANES+i]);
    end
    next_val = $signed({{(NW-CW){1'b0}}, count_q})
             + $signed({{(NW-PW){1'b0}}, n_arr})
             - $signed({{(NW-PW){1'b0}}, n_dep});
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    if (next_val[NW-1]) begin
      udf_evt = 1'b1;
      count_d = '0;
    end else if (next_val > $signed(NW'(CAPACITY))) begin
      ovf_evt = 1'b1;
      count_d = CW'(CAPACITY);
    end else begin
      count_d = next_val[CW-1:0];
    end
    // A new error in the clearing cycle wins over the clear.
    overflow_d  = (overflow_q  & ~io.clr_err) | ovf_evt;
    underflow_d = (underflow_q & ~io.clr_err) | udf_evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign io.count     = count_q;
  assign io.full      = (count_q == CW'(CAPACITY));
  assign io.empty     = (count_q == '0);
  assign io.overflow  = overflow_q;
  assign io.underflow = underflow_q;
endmodule
